regfile_sb: RTL and testbench
=============================

# regfile_sb

Parametrised register file with an integrated load-use scoreboard for the pipelined MIPS core. It provides NREAD combinational read ports, one clocked write port and an optional write-to-read bypass. A per-register busy bit is set when a long-latency producer (load) issues and cleared on its writeback. The decode stage uses the per-port busy outputs to generate stalls instead of recomputing hazards from pipeline registers.

## Interface
- WIDTH, 32, data width in bits
- NREGS, 32, number of architectural registers; register 0 is hardwired to zero
- NREAD, 2, number of read ports
- BYPASS, 1, 1 = same-cycle write data forwarded to matching read ports; 0 = no forwarding
- AW, $clog2(NREGS), address width (derived, not overridden)
- CW, $clog2(NREGS+1), pending-counter width (derived)

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high
- we  in  1  write enable; also clears the busy bit of wa
- wa  in  AW  write address
- wd  in  WIDTH  write data
- ra  in  NREAD*AW  packed read addresses; port i = ra[i*AW +: AW]
- rd  out  NREAD*WIDTH  packed read data; port i = rd[i*WIDTH +: WIDTH]
- set_en  in  1  mark set_addr busy (producer issued)
- set_addr  in  AW  register to mark busy
- busy  out  NREAD  port i reads a register with an outstanding producer
- pending  out  CW  number of busy registers
- err  out  1  sticky protocol error flag

## Operation
- Reset: all registers 0, all busy bits 0, pending 0, err 0. rd reads as 0 immediately after reset.
- Write: on the clk edge with we=1 and wa!=0, reg[wa] <= wd. Writes to address 0 are ignored. Writes to wa >= NREGS are ignored.
- Read: rd[i] is combinational and equals 0 when ra[i]==0.
  - BYPASS=1 and we && wa==ra[i] && wa!=0: rd[i] = wd.
  - Otherwise rd[i] = reg[ra[i]].
- Scoreboard per register, sb[r]:
  - set_en && set_addr!=0 && !sb[set_addr]: sb[set_addr] <= 1.
  - set_en to a register that is already busy: illegal. err <= 1 and stays 1 until reset; sb and pending are unchanged.
  - set_en with set_addr==0: ignored, no error.
  - we && wa!=0: sb[wa] <= 0, unless the same-cycle set targets the same address, in which case set wins and sb stays 1.
  - we to a register that is not busy: a normal ALU writeback. No error, sb unchanged.
- busy[i] = sb[ra[i]] & ~(BYPASS && we && wa==ra[i] && wa!=0 && !(set_en && set_addr==wa)). busy[i] is always 0 for ra[i]==0.
- pending tracks popcount(sb) incrementally: +1 on an accepted set, −1 on a clear of a busy bit, net 0 when both happen in the same cycle. It never exceeds NREGS−1.

## Timing
- Write latency: 1 cycle to storage. Read-after-write in the same cycle returns the new data only when BYPASS=1.
- Set latency: busy is visible on the cycle after the set_en edge.
- Clear latency:
  - BYPASS=1: busy drops combinationally in the writeback cycle.
  - BYPASS=0: busy drops the cycle after.
- pending and err update on the clk edge; there are no combinational paths from inputs to them.
- Reset asserted mid-operation clears storage, sb, pending and err asynchronously. Inputs are ignored while reset is high.
- Simultaneous set and clear of different registers are both applied in the same edge.

## Structure
- Shared package regfile_pkg holds:
  - default WIDTH, NREGS, NREAD constants
  - localparam ZERO_REG = 0
  - the packed-port index helper functions
- One sub-module, rf_read_port, instantiated NREAD times. It contains the address decode, the zero-register forcing, the bypass compare and the busy-mask logic for a single port.
- Storage, scoreboard bits, the pending counter and err live in the top module.

## Test plan
- Reset: assert reset mid-run with sb and pending nonzero → after release, rd=0 on every address, busy=0, pending=0, err=0.
- Bypass: BYPASS=1; we=1, wa=5, wd=32'hDEADBEEF, ra0=5 in the same cycle → rd0=DEADBEEF in that cycle, and still DEADBEEF the next cycle with we=0. With BYPASS=0, the same cycle returns the old value 0.
- Zero register: we=1, wa=0, wd=32'hFFFFFFFF, then ra1=0 → rd1=0 and busy1=0. set_en to address 0 → pending stays 0, err stays 0.
- Load-use: set r7, ra0=7 → busy0=1 next cycle and pending=1. Writeback we, wa=7 → busy0=0 in that cycle (BYPASS=1), pending=0 next cycle.
- Simultaneous set and clear on r3 while r3 is busy → busy stays 1 and pending is unchanged. Set r4 while clearing r3 → r3 free, r4 busy, pending unchanged.
- Protocol error: set r9 twice with no writeback between → err=1 after the second edge, pending=1, and err stays high until reset.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared constants and packed-port helpers for the register file with load-use scoreboard.
package regfile_pkg;

  localparam int unsigned WIDTH_DEF = 32;
  localparam int unsigned NREGS_DEF = 32;
  localparam int unsigned NREAD_DEF = 2;
  localparam int unsigned ZERO_REG  = 0;

  // LSB of slot `port` in a packed vector of `w`-bit slots
  function automatic int unsigned port_lsb(input int unsigned port, input int unsigned w);
    return port * w;
  endfunction

endpackage

// File: rtl/rf_read_port.sv
// One combinational read port: address decode, r0 forcing, write bypass and busy masking.
module rf_read_port
  import regfile_pkg::*;
#(
  parameter int unsigned WIDTH  = WIDTH_DEF,
  parameter int unsigned NSLOT  = NREGS_DEF,
  parameter int unsigned AW     = 5,
  parameter int unsigned BYPASS = 1
) (
  input  logic [AW-1:0]          ra,
  input  logic [NSLOT*WIDTH-1:0] mem_flat,
  input  logic [NSLOT-1:0]       sb,
  input  logic                   we_ok,
  input  logic [AW-1:0]          wa,
  input  logic [WIDTH-1:0]       wd,
  input  logic                   set_en,
  input  logic [AW-1:0]          set_addr,
  output logic [WIDTH-1:0]       rd,
  output logic                   busy
);

  logic ra_live;
  logic hit;
  logic set_same;

  // we_ok already excludes r0, so a hit implies a live address
  always_comb begin
    ra_live  = (ra != AW'(ZERO_REG));
    hit      = (BYPASS != 0) && we_ok && (wa == ra);
    set_same = set_en && (set_addr == wa);
    rd       = '0;
    busy     = 1'b0;
    if (ra_live) begin
      rd   = hit ? wd : mem_flat[port_lsb(32'(ra), WIDTH) +: WIDTH];
      busy = sb[ra] && !(hit && !set_same);
    end
  end

endmodule

// File: rtl/regfile_sb.sv
// Register file with NREAD read ports, one write port and a per-register load-use scoreboard.
module regfile_sb
  import regfile_pkg::*;
#(
  parameter  int unsigned WIDTH  = WIDTH_DEF,
  parameter  int unsigned NREGS  = NREGS_DEF,
  parameter  int unsigned NREAD  = NREAD_DEF,
  parameter  int unsigned BYPASS = 1,
  localparam int unsigned AW     = $clog2(NREGS),
  localparam int unsigned CW     = $clog2(NREGS + 1)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   we,
  input  logic [AW-1:0]          wa,
  input  logic [WIDTH-1:0]       wd,
  input  logic [NREAD*AW-1:0]    ra,
  output logic [NREAD*WIDTH-1:0] rd,
  input  logic                   set_en,
  input  logic [AW-1:0]          set_addr,
  output logic [NREAD-1:0]       busy,
  output logic [CW-1:0]          pending,
  output logic                   err
);

  localparam int unsigned NSLOT = 32'(1) << AW;

  logic [NSLOT-1:0][WIDTH-1:0] mem;
  logic [NSLOT*WIDTH-1:0]      mem_flat;
  logic [NSLOT-1:0]            sb;
  logic [NSLOT-1:0]            sb_nxt;
  logic [NSLOT-1:0]            reg_ok;
  logic                        we_ok;
  logic                        sa_ok;
  logic                        wb_same;
  logic                        set_ok;
  logic                        set_bad;
  logic                        dec;

  // Writable/trackable slots: everything below NREGS except r0
  for (genvar r = 0; r < NSLOT; r++) begin : g_ok
    if ((r < NREGS) && (r != ZERO_REG)) begin : g_live
      assign reg_ok[r] = 1'b1;
    end else begin : g_dead
      assign reg_ok[r] = 1'b0;
    end
  end

  assign mem_flat = mem;

  // A set to a busy register is legal only when that register's writeback lands in the same edge
  always_comb begin
    we_ok   = we && reg_ok[wa];
    sa_ok   = set_en && reg_ok[set_addr];
    wb_same = we_ok && (wa == set_addr);
    set_ok  = sa_ok && (!sb[set_addr] || wb_same);
    set_bad = sa_ok && sb[set_addr] && !wb_same;
    dec     = we_ok && sb[wa];
    sb_nxt  = sb;
    if (we_ok) sb_nxt[wa] = 1'b0;
    if (set_ok) sb_nxt[set_addr] = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem     <= '0;
      sb      <= '0;
      pending <= '0;
      err     <= 1'b0;
    end else begin
      if (we_ok) mem[wa] <= wd;
      sb      <= sb_nxt;
      pending <= pending + CW'(set_ok) - CW'(dec);
      err     <= err | set_bad;
    end
  end

  for (genvar i = 0; i < NREAD; i++) begin : g_port
    rf_read_port #(
      .WIDTH (WIDTH),
      .NSLOT (NSLOT),
      .AW    (AW),
      .BYPASS(BYPASS)
    ) u_port (
      .ra      (ra[port_lsb(i, AW) +: AW]),
      .mem_flat(mem_flat),
      .sb      (sb),
      .we_ok   (we_ok),
      .wa      (wa),
      .wd      (wd),
      .set_en  (set_en),
      .set_addr(set_addr),
      .rd      (rd[port_lsb(i, WIDTH) +: WIDTH]),
      .busy    (busy[i])
    );
  end

endmodule

// File: tb/tb_regfile_sb.sv
// Bench for regfile_sb: bypass and non-bypass instances driven together against an array-based model.
module tb_regfile_sb;

  logic        clk;
  logic        reset;
  logic        we;
  logic [4:0]  wa;
  logic [31:0] wd;
  logic [9:0]  ra;
  logic        set_en;
  logic [4:0]  set_addr;
  logic [63:0] rd_b, rd_n;
  logic [1:0]  busy_b, busy_n;
  logic [5:0]  pending_b, pending_n;
  logic        err_b, err_n;

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] m_mem [32];
  bit          m_sb  [32];
  bit          m_err;

  regfile_sb #(.BYPASS(1)) u_byp (
    .clk(clk), .reset(reset), .we(we), .wa(wa), .wd(wd), .ra(ra), .rd(rd_b),
    .set_en(set_en), .set_addr(set_addr), .busy(busy_b), .pending(pending_b), .err(err_b)
  );

  regfile_sb #(.BYPASS(0)) u_nob (
    .clk(clk), .reset(reset), .we(we), .wa(wa), .wd(wd), .ra(ra), .rd(rd_n),
    .set_en(set_en), .set_addr(set_addr), .busy(busy_n), .pending(pending_n), .err(err_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] exp_rd(input bit bp, input logic [4:0] a);
    if (a == 0) return 32'h0;
    if (bp && we && wa == a) return wd;
    return m_mem[a];
  endfunction

  function automatic bit exp_busy(input bit bp, input logic [4:0] a);
    if (a == 0) return 1'b0;
    return m_sb[a] && !(bp && we && wa == a && !(set_en && set_addr == wa));
  endfunction

  function automatic int popcnt();
    int c = 0;
    for (int r = 0; r < 32; r++) c += int'(m_sb[r]);
    return c;
  endfunction

  task automatic model_clear();
    for (int r = 0; r < 32; r++) begin
      m_mem[r] = '0;
      m_sb[r]  = 1'b0;
    end
    m_err = 1'b0;
  endtask

  // Apply one clock edge's worth of the architectural rules
  task automatic model_edge();
    bit freed, ok, bad;
    freed = we && wa != 0 && wa == set_addr;
    ok    = set_en && set_addr != 0 && (!m_sb[set_addr] || freed);
    bad   = set_en && set_addr != 0 && m_sb[set_addr] && !freed;
    if (we && wa != 0) begin
      m_mem[wa] = wd;
      m_sb[wa]  = 1'b0;
    end
    if (ok) m_sb[set_addr] = 1'b1;
    if (bad) m_err = 1'b1;
  endtask

  task automatic check_comb();
    logic [4:0] a;
    for (int p = 0; p < 2; p++) begin
      a = ra[p*5 +: 5];
      check($sformatf("rd_byp%0d", p), rd_b[p*32 +: 32], exp_rd(1'b1, a));
      check($sformatf("rd_nob%0d", p), rd_n[p*32 +: 32], exp_rd(1'b0, a));
      check($sformatf("busy_byp%0d", p), 32'(busy_b[p]), 32'(exp_busy(1'b1, a)));
      check($sformatf("busy_nob%0d", p), 32'(busy_n[p]), 32'(exp_busy(1'b0, a)));
    end
  endtask

  task automatic check_seq();
    check("pending_byp", 32'(pending_b), 32'(popcnt()));
    check("pending_nob", 32'(pending_n), 32'(popcnt()));
    check("err_byp", 32'(err_b), 32'(m_err));
    check("err_nob", 32'(err_n), 32'(m_err));
  endtask

  task automatic set_in(input logic w, input logic [4:0] a, input logic [31:0] d,
                        input logic s, input logic [4:0] sa,
                        input logic [4:0] r0, input logic [4:0] r1);
    we = w; wa = a; wd = d; set_en = s; set_addr = sa; ra = {r1, r0};
  endtask

  task automatic cycle();
    #1;
    check_comb();
    @(posedge clk);
    model_edge();
    #1;
    check_seq();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    model_clear();
    check_seq();
    check("rst_busy_byp", 32'(busy_b), 32'h0);
    @(posedge clk);
    #1;
    set_in(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0, 5'd0);
    reset = 1'b0;
  endtask

  task automatic sweep_zero();
    for (int a = 0; a < 32; a++) begin
      set_in(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'(a), 5'(31 - a));
      #1;
      check_comb();
    end
  endtask

  function automatic logic [4:0] raddr();
    if ($urandom_range(0, 3) == 0) return 5'($urandom_range(0, 31));
    return 5'($urandom_range(0, 7));
  endfunction

  initial begin
    set_in(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0, 5'd0);
    reset = 1'b0;
    #2;
    do_reset();
    sweep_zero();

    // same-cycle bypass versus stored value
    set_in(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 5'd5, 5'd0);
    #1;
    check("byp_same", rd_b[31:0], 32'hDEADBEEF);
    check("nob_same", rd_n[31:0], 32'h0);
    cycle();
    set_in(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd5, 5'd0);
    #1;
    check("byp_next", rd_b[31:0], 32'hDEADBEEF);
    check("nob_next", rd_n[31:0], 32'hDEADBEEF);
    cycle();

    // register zero
    set_in(1'b1, 5'd0, 32'hFFFFFFFF, 1'b0, 5'd0, 5'd0, 5'd0);
    cycle();
    set_in(1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 5'd0, 5'd0);
    #1;
    check("zero_rd1", rd_b[63:32], 32'h0);
    check("zero_busy1", 32'(busy_b[1]), 32'h0);
    cycle();
    check("zero_pend", 32'(pending_b), 32'h0);
    check("zero_err", 32'(err_b), 32'h0);

    // load-use on r7
    set_in(1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 5'd7, 5'd0);
    cycle();
    set_in(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd7, 5'd0);
    #1;
    check("lu_busy", 32'(busy_b[0]), 32'h1);
    check("lu_pend", 32'(pending_b), 32'h1);
    cycle();
    set_in(1'b1, 5'd7, 32'h00001234, 1'b0, 5'd0, 5'd7, 5'd0);
    #1;
    check("lu_clr_byp", 32'(busy_b[0]), 32'h0);
    check("lu_clr_nob", 32'(busy_n[0]), 32'h1);
    cycle();
    check("lu_pend0", 32'(pending_b), 32'h0);
    set_in(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd7, 5'd0);
    #1;
    check("lu_nob_after", 32'(busy_n[0]), 32'h0);
    cycle();

    // set and clear of r3 in one edge, then set r4 while clearing r3
    set_in(1'b0, 5'd0, 32'h0, 1'b1, 5'd3, 5'd3, 5'd4);
    cycle();
    set_in(1'b1, 5'd3, 32'h33, 1'b1, 5'd3, 5'd3, 5'd4);
    #1;
    check("ss_busy_byp", 32'(busy_b[0]), 32'h1);
    cycle();
    check("ss_pend", 32'(pending_b), 32'h1);
    check("ss_err", 32'(err_b), 32'h0);
    set_in(1'b1, 5'd3, 32'h333, 1'b1, 5'd4, 5'd3, 5'd4);
    cycle();
    set_in(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd3, 5'd4);
    #1;
    check("sc_busy", 32'(busy_b), 32'h2);
    check("sc_pend", 32'(pending_b), 32'h1);
    cycle();
    set_in(1'b1, 5'd4, 32'h44, 1'b0, 5'd0, 5'd4, 5'd3);
    cycle();

    // double set of r9
    set_in(1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 5'd9, 5'd0);
    cycle();
    cycle();
    check("err_set", 32'(err_b), 32'h1);
    check("err_pend", 32'(pending_b), 32'h1);
    set_in(1'b1, 5'd9, 32'h99, 1'b1, 5'd10, 5'd9, 5'd10);
    cycle();
    set_in(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd9, 5'd10);
    repeat (3) cycle();
    check("err_sticky", 32'(err_b), 32'h1);

    // reset while r10 is busy and err is set
    #2;
    do_reset();
    check("rst_pend", 32'(pending_b), 32'h0);
    check("rst_err", 32'(err_b), 32'h0);
    sweep_zero();

    // random traffic concentrated on a few registers to provoke hazards
    for (int n = 0; n < 600; n++) begin
      if (n % 150 == 149) do_reset();
      set_in(1'($urandom_range(0, 1)), raddr(), $urandom(),
             1'($urandom_range(0, 99) < 35), raddr(), raddr(), raddr());
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
